// File: rtl/reaction_display_driver_if.sv
// Load/display bundle between the reaction-time core and the display driver.
interface reaction_display_driver_if;
  logic [13:0] value_in;
  logic        load;
  logic        blank;
  logic        busy;
  logic        overflow;
  logic [6:0]  seg;
  logic [3:0]  an;

  modport master (output value_in, load, blank, input busy, overflow, seg, an);
  modport slave  (input value_in, load, blank, output busy, overflow, seg, an);
endinterface

// File: rtl/reaction_display_driver.sv
// Binary-to-BCD converter (shift-add-3, one bit per clock) feeding a
// four-digit multiplexed 7-segment scanner with leading-zero suppression.
module reaction_display_driver #(
  parameter int REFRESH_DIV    = 2500,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  reaction_display_driver_if.slave    bus
);

  localparam int            RW       = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [6:0]    SEG_RST  = SEG_ACTIVE_LOW ? 7'h40 : 7'h3F;
  localparam logic [3:0]    AN_RST   = AN_ACTIVE_LOW ? 4'b1110 : 4'b0001;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++)
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    case (d)
      4'd0:    seg_pat = 7'h3F;
      4'd1:    seg_pat = 7'h06;
      4'd2:    seg_pat = 7'h5B;
      4'd3:    seg_pat = 7'h4F;
      4'd4:    seg_pat = 7'h66;
      4'd5:    seg_pat = 7'h6D;
      4'd6:    seg_pat = 7'h7D;
      4'd7:    seg_pat = 7'h07;
      4'd8:    seg_pat = 7'h7F;
      4'd9:    seg_pat = 7'h6F;
      default: seg_pat = 7'h00;
    endcase
  endfunction

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic          busy_q, overflow_q, ovf_pend_q;
  logic [15:0]   disp_q;
  logic [13:0]   bin_q;
  logic [15:0]   bcd_q;
  logic [29:0]   shift_d;
  logic [RW-1:0] ref_q;
  logic [1:0]    dig_q;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic [3:0]    show;
  logic [3:0]    cur_digit;
  logic          load_ok;

  assign load_ok = (state_q == IDLE) && bus.load;
  assign shift_d = {add3(bcd_q), bin_q} << 1;

  // Conversion control and committed display register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      ovf_pend_q <= 1'b0;
      disp_q     <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: if (bus.load) begin
          state_q    <= SHIFT;
          cnt_q      <= 4'd0;
          busy_q     <= 1'b1;
          ovf_pend_q <= (bus.value_in > 14'd9999);
        end
        SHIFT: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd13) state_q <= COMMIT;
        end
        COMMIT: begin
          disp_q     <= bcd_q;
          overflow_q <= ovf_pend_q;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Shift register datapath carries no reset; it is always reloaded before use
  always_ff @(posedge clk) begin
    if (load_ok) begin
      bin_q <= (bus.value_in > 14'd9999) ? 14'd9999 : bus.value_in;
      bcd_q <= 16'h0000;
    end else if (state_q == SHIFT) begin
      {bcd_q, bin_q} <= shift_d;
    end
  end

  assign show      = {|disp_q[15:12], |disp_q[15:8], |disp_q[15:4], 1'b1};
  assign cur_digit = disp_q[{dig_q, 2'b00} +: 4];

  always_comb begin
    seg_d = 7'h00;
    an_d  = 4'b0000;
    if (!bus.blank) begin
      an_d = 4'b0001 << dig_q;
      if (show[dig_q]) seg_d = seg_pat(cur_digit);
    end
    if (SEG_ACTIVE_LOW) seg_d = ~seg_d;
    if (AN_ACTIVE_LOW)  an_d  = ~an_d;
  end

  // Scan counters and registered pin drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q <= '0;
      dig_q <= 2'd0;
      seg_q <= SEG_RST;
      an_q  <= AN_RST;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
      if (ref_q == REF_LAST) begin
        ref_q <= '0;
        dig_q <= dig_q + 2'd1;
      end else begin
        ref_q <= ref_q + 1'b1;
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.overflow = overflow_q;
  assign bus.seg      = seg_q;
  assign bus.an       = an_q;

endmodule

// File: tb/tb_reaction_display_driver.sv
// Directed bench for reaction_display_driver with a cycle-level reference model.
module tb_reaction_display_driver;
  localparam int RD = 4;
  localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic clk = 1'b0;
  logic rst_n;
  bit   run_cmp = 1'b0;
  int   checks = 0;
  int   errors = 0;

  reaction_display_driver_if bus_if ();

  reaction_display_driver #(.REFRESH_DIV(RD), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: decimal value, edge count since reset, remaining conversion cycles
  int         m_disp, m_pend, m_cnt, m_edges;
  bit         m_busy, m_ovf, m_povf;
  logic [6:0] e_seg;
  logic [3:0] e_an;

  function automatic logic [6:0] m_seg_f(input int v, input int idx, input bit blk);
    int pw;
    pw = 1;
    for (int k = 0; k < idx; k++) pw = pw * 10;
    if (blk) return 7'h7F;
    if (idx != 0 && v < pw) return 7'h7F;
    return ~PAT[(v / pw) % 10];
  endfunction

  function automatic logic [3:0] m_an_f(input int idx, input bit blk);
    logic [3:0] t;
    t = 4'b0001 << idx;
    return blk ? 4'hF : ~t;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_disp <= 0; m_pend <= 0; m_cnt <= 0; m_edges <= 0;
      m_busy <= 1'b0; m_ovf <= 1'b0; m_povf <= 1'b0;
      e_seg <= 7'b1000000; e_an <= 4'b1110;
    end else begin
      e_seg   <= m_seg_f(m_disp, (m_edges / RD) % 4, bus_if.blank);
      e_an    <= m_an_f((m_edges / RD) % 4, bus_if.blank);
      m_edges <= m_edges + 1;
      if (m_cnt == 0) begin
        if (bus_if.load) begin
          m_pend <= (int'(bus_if.value_in) > 9999) ? 9999 : int'(bus_if.value_in);
          m_povf <= (int'(bus_if.value_in) > 9999);
          m_cnt  <= 15;
          m_busy <= 1'b1;
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_disp <= m_pend;
          m_ovf  <= m_povf;
          m_busy <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("model_seg", bus_if.seg, e_seg);
      chk("model_an", bus_if.an, e_an);
      chk("model_busy", bus_if.busy, m_busy);
      chk("model_ovf", bus_if.overflow, m_ovf);
    end
  end

  task automatic conv(input int v, input int sec, input int v2, input string nm);
    int n;
    bus_if.value_in = 14'(v);
    bus_if.load = 1'b1;
    @(posedge clk); #1;
    bus_if.load = 1'b0;
    n = 0;
    while (bus_if.busy === 1'b1 && n < 40) begin
      n++;
      if (n == sec) begin
        bus_if.value_in = 14'(v2);
        bus_if.load = 1'b1;
      end else begin
        bus_if.load = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus_if.load = 1'b0;
    chk({nm, "_busy_cycles"}, n, 15);
  endtask

  task automatic digit_chk(input logic [3:0] an_pat, input logic [6:0] seg_exp, input string nm);
    int n;
    @(posedge clk); #1;
    n = 0;
    while (bus_if.an !== an_pat && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) chk({nm, "_timeout_an"}, bus_if.an, an_pat);
    else         chk(nm, bus_if.seg, seg_exp);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    rst_n = 1'b0;
    bus_if.value_in = 14'd0;
    bus_if.load = 1'b0;
    bus_if.blank = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run_cmp = 1'b1;
    chk("rst_an", bus_if.an, 4'b1110);
    chk("rst_seg", bus_if.seg, 7'b1000000);
    chk("rst_busy", bus_if.busy, 1'b0);
    chk("rst_ovf", bus_if.overflow, 1'b0);
    rst_n = 1'b1;

    repeat (5) @(posedge clk); #1;
    chk("scan1_an", bus_if.an, 4'b1101);
    chk("scan1_seg", bus_if.seg, 7'b1111111);
    for (int k = 2; k < 5; k++) begin
      repeat (4) @(posedge clk); #1;
      chk("scan_an", bus_if.an, (k == 4) ? 4'b1110 : ((k == 2) ? 4'b1011 : 4'b0111));
      chk("scan_seg", bus_if.seg, (k == 4) ? 7'b1000000 : 7'b1111111);
    end

    conv(1234, 0, 0, "v1234");
    digit_chk(4'b1110, 7'b0011001, "v1234_d0");
    digit_chk(4'b1101, 7'b0110000, "v1234_d1");
    digit_chk(4'b1011, 7'b0100100, "v1234_d2");
    digit_chk(4'b0111, 7'b1111001, "v1234_d3");
    chk("v1234_ovf", bus_if.overflow, 1'b0);

    conv(12000, 0, 0, "v12000");
    digit_chk(4'b1110, 7'b0010000, "sat_d0");
    digit_chk(4'b1101, 7'b0010000, "sat_d1");
    digit_chk(4'b1011, 7'b0010000, "sat_d2");
    digit_chk(4'b0111, 7'b0010000, "sat_d3");
    chk("sat_ovf", bus_if.overflow, 1'b1);

    conv(250, 0, 0, "v250");
    digit_chk(4'b1110, 7'b1000000, "v250_d0");
    digit_chk(4'b1101, 7'b0010010, "v250_d1");
    digit_chk(4'b1011, 7'b0100100, "v250_d2");
    digit_chk(4'b0111, 7'b1111111, "v250_d3");
    chk("v250_ovf", bus_if.overflow, 1'b0);

    conv(500, 5, 42, "v500");
    digit_chk(4'b1110, 7'b1000000, "v500_d0");
    digit_chk(4'b1101, 7'b1000000, "v500_d1");
    digit_chk(4'b1011, 7'b0010010, "v500_d2");
    digit_chk(4'b0111, 7'b1111111, "v500_d3");
    chk("v500_idle", bus_if.busy, 1'b0);

    bus_if.value_in = 14'd1234;
    bus_if.load = 1'b1;
    @(posedge clk); #1;
    bus_if.load = 1'b0;
    repeat (7) @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", bus_if.busy, 1'b0);
    chk("abort_seg", bus_if.seg, 7'b1000000);
    chk("abort_an", bus_if.an, 4'b1110);
    @(posedge clk); #1;
    rst_n = 1'b1;
    conv(9, 0, 0, "v9");
    digit_chk(4'b1110, 7'b0010000, "v9_d0");
    digit_chk(4'b1101, 7'b1111111, "v9_d1");

    conv(8888, 0, 0, "v8888");
    digit_chk(4'b1011, 7'b0000000, "v8888_d2");
    bus_if.blank = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      chk("blank_an", bus_if.an, 4'b1111);
      chk("blank_seg", bus_if.seg, 7'b1111111);
      @(posedge clk); #1;
    end
    bus_if.blank = 1'b0;
    @(posedge clk); #1;
    chk("unblank_seg", bus_if.seg, 7'b0000000);
    repeat (8) @(posedge clk);
    #1;

    run_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
